wishbone_mux_n: RTL and testbench
=================================

Name: wishbone_mux_n

Overview:
Parametrised N-slave Wishbone classic demultiplexer. It replaces the fixed three-slave bus mux between the Caravel management Wishbone port and the user-area slaves (IRAM mux, DRAM mux, peripherals). It adds a registered request/response FSM, error responses for unmapped addresses, a per-transaction ack timeout and a saturating error counter with an interrupt pulse.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..8)
BASE_ADDRS, {32'h3000_C000,32'h3000_8000,32'h3000_4000,32'h3000_0000}, flattened 32*NUM_SLAVES base addresses; slave i uses bits [32*i+31:32*i]
ADDR_WIDTHS, {8'd11,8'd11,8'd11,8'd11}, flattened 8*NUM_SLAVES byte-address window widths per slave
TIMEOUT_CYCLES, 255, cycles to wait for a slave ack before an error response; 0 disables the timeout
ERR_DATA, 32'hDEAD_BEEF, value returned on wbs_dat_o with an error response

Ports:
wb_clk_i  in  1  system clock
wb_rstn_i  in  1  asynchronous active-low reset
wbs_stb_i  in  1  master strobe
wbs_cyc_i  in  1  master cycle
wbs_we_i  in  1  master write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  master write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  response ack (success or error)
wbs_err_o  out  1  error qualifier, valid only with wbs_ack_o
wbs_dat_o  out  32  read data
s_stb_o  out  NUM_SLAVES  per-slave strobe
s_cyc_o  out  NUM_SLAVES  per-slave cycle
s_we_o  out  1  broadcast write enable (latched)
s_sel_o  out  4  broadcast byte selects (latched)
s_dat_o  out  32  broadcast write data (latched)
s_adr_o  out  32  broadcast full byte address (latched, not rebased)
s_ack_i  in  NUM_SLAVES  per-slave ack
s_dat_i  in  32*NUM_SLAVES  per-slave read data, flattened
err_irq_o  out  1  one-cycle pulse on every error response
err_count_o  out  16  saturating count of error responses

Behaviour:
- Reset: FSM in IDLE. wbs_ack_o, wbs_err_o, s_stb_o, s_cyc_o and err_irq_o are 0. wbs_dat_o, s_we_o, s_sel_o, s_dat_o, s_adr_o and err_count_o are 0.
- Decode: slave i hits when (wbs_adr_i >> ADDR_WIDTHS[i]) == (BASE_ADDRS[i] >> ADDR_WIDTHS[i]). With multiple hits, the lowest index wins.
- FSM states are IDLE, BUSY and RESP.
- IDLE, cyc&stb with a hit:
  - latch we/sel/dat/adr and the slave index;
  - clear the timeout counter;
  - go to BUSY.
- IDLE, cyc&stb with a miss: go to RESP with the error flag set.
- BUSY:
  - s_stb_o[idx] and s_cyc_o[idx] are 1; all other bits are 0.
  - On s_ack_i[idx], capture s_dat_i slice idx and go to RESP with no error. Acks from unselected slaves are ignored.
  - The counter increments each cycle without an ack. When it reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with error.
  - If ack and the timeout coincide, the ack wins.
- BUSY with wbs_cyc_i dropped (abort): return to IDLE. Slave strobes drop next cycle. There is no master ack, no error and no count.
- RESP:
  - wbs_ack_o=1 for exactly one cycle.
  - wbs_dat_o is the captured data on success, or ERR_DATA on error.
  - wbs_err_o equals the error flag.
  - On error, err_irq_o=1 in the same cycle and err_count_o increments, saturating at 16'hFFFF.
  - Next state is IDLE.
- Outside RESP, wbs_ack_o and wbs_err_o are 0. wbs_dat_o holds its last value.
- Latency:
  - hit: master stb seen at cycle 0 → s_stb_o at cycle 1 → slave ack at cycle t → wbs_ack_o at cycle t+1;
  - miss: wbs_ack_o at cycle 1;
  - timeout: wbs_ack_o at cycle TIMEOUT_CYCLES+1.
- Late slave ack after a timeout or abort arrives in IDLE or RESP and is ignored.
- A master holding stb high after ack starts a new transaction in the IDLE cycle that follows RESP.
- Reset asserted mid-transaction forces IDLE immediately (asynchronous). All strobes and the ack drop the same instant.
- Write data is never modified. sel is passed through unchanged.

Test Plan:
- Read 0x3000_0010, slave0 acks 2 cycles after its strobe with 0x1234_5678 → s_stb_o=4'b0001 from cycle 1; wbs_ack_o=1, wbs_err_o=0, wbs_dat_o=0x1234_5678 for one cycle.
- Write 0x3000_4004 data 0xA5A5_A5A5 sel 4'b0011 → only s_stb_o[1] asserted; s_dat_o=0xA5A5_A5A5, s_sel_o=4'b0011, s_we_o=1; single master ack with no error.
- Access 0x2000_0000 (unmapped) → wbs_ack_o=1, wbs_err_o=1 and wbs_dat_o=0xDEAD_BEEF at cycle 1; err_irq_o pulses; err_count_o=1; no s_stb_o bit ever set.
- Slave2 never acks, TIMEOUT_CYCLES=255 → error ack at cycle 256; s_stb_o drops; a slave2 ack injected 3 cycles later is ignored (no second wbs_ack_o).
- Drop wbs_cyc_i in BUSY, then assert wb_rstn_i low mid-BUSY on a separate run → abort: no ack, err_count_o unchanged. Reset: all outputs 0 asynchronously and FSM in IDLE after release.
- Force err_count_o to 16'hFFFE, then issue 3 unmapped accesses → count saturates at 16'hFFFF; err_irq_o still pulses each time.

Source files
------------

// File: rtl/wishbone_mux_n.sv
// N-slave Wishbone classic demultiplexer with a registered request/response FSM,
// error responses for unmapped addresses and ack timeouts, and a saturating error counter.
module wishbone_mux_n #(
    parameter int unsigned              NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS     = {32'h3000_C000, 32'h3000_8000,
                                                          32'h3000_4000, 32'h3000_0000},
    parameter logic [8*NUM_SLAVES-1:0]  ADDR_WIDTHS    = {8'd11, 8'd11, 8'd11, 8'd11},
    parameter int unsigned              TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rstn_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_dat_i,
    input  logic [31:0]                wbs_adr_i,
    output logic                       wbs_ack_o,
    output logic                       wbs_err_o,
    output logic [31:0]                wbs_dat_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic                       s_we_o,
    output logic [3:0]                 s_sel_o,
    output logic [31:0]                s_dat_o,
    output logic [31:0]                s_adr_o,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    output logic                       err_irq_o,
    output logic [15:0]                err_count_o
);
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] dat;
        logic [AW-1:0] adr;
    } req_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    req_t             req_q;
    logic [IDX_W-1:0] idx_q, idx_d_c, hit_idx_c;
    logic [TO_W-1:0]  to_cnt_q;
    logic             hit_c, start_c, resp_err_c, sel_ack_c, timeout_c, enter_resp_c;

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((wbs_adr_i >> ADDR_WIDTHS[8*i +: 8]) ==
                (BASE_ADDRS[32*i +: 32] >> ADDR_WIDTHS[8*i +: 8])) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    assign sel_ack_c    = s_ack_i[idx_q];
    assign timeout_c    = TO_EN && (to_cnt_q == TO_LAST);
    assign enter_resp_c = (state_d == RESP);
    assign idx_d_c      = start_c ? hit_idx_c : idx_q;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Abort beats ack, and ack beats timeout.
    always_comb begin
        state_d    = state_q;
        start_c    = 1'b0;
        resp_err_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (hit_c) begin
                        state_d = BUSY;
                        start_c = 1'b1;
                    end else begin
                        state_d    = RESP;
                        resp_err_c = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack_c) begin
                    state_d = RESP;
                end else if (timeout_c) begin
                    state_d    = RESP;
                    resp_err_c = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, timeout counter and registered master/slave outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            req_q       <= '0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            wbs_dat_o   <= '0;
            err_irq_o   <= 1'b0;
            err_count_o <= '0;
            s_stb_o     <= '0;
            s_cyc_o     <= '0;
        end else begin
            if (start_c) begin
                req_q <= '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i, adr: wbs_adr_i};
                idx_q <= hit_idx_c;
            end
            if (start_c)                to_cnt_q <= '0;
            else if (state_q == BUSY)   to_cnt_q <= to_cnt_q + TO_W'(1);
            wbs_ack_o <= enter_resp_c;
            wbs_err_o <= enter_resp_c && resp_err_c;
            err_irq_o <= enter_resp_c && resp_err_c;
            if (enter_resp_c)
                wbs_dat_o <= resp_err_c ? ERR_DATA : s_dat_i[DW*idx_q +: DW];
            if (enter_resp_c && resp_err_c && (err_count_o != '1))
                err_count_o <= err_count_o + CW'(1);
            s_stb_o <= (state_d == BUSY) ? (NUM_SLAVES'(1) << idx_d_c) : '0;
            s_cyc_o <= (state_d == BUSY) ? (NUM_SLAVES'(1) << idx_d_c) : '0;
        end
    end

    assign s_we_o  = req_q.we;
    assign s_sel_o = req_q.sel;
    assign s_dat_o = req_q.dat;
    assign s_adr_o = req_q.adr;

endmodule

// File: tb/tb_wishbone_mux_n.sv
// Randomised bench for wishbone_mux_n: a transaction-level reference model is compared
// against every DUT output each cycle, plus directed scenarios with hand-computed values.
module tb_wishbone_mux_n;
    localparam int          NS    = 4;
    localparam int          TO    = 255;
    localparam int          NEVER = 100000;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
    localparam logic [31:0] BASE [NS] = '{32'h3000_0000, 32'h3000_4000, 32'h3000_8000, 32'h3000_C000};
    localparam int          WID  [NS] = '{11, 11, 11, 11};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] mdat = '0, adr = '0;
    logic ack, err, irq, s_we;
    logic [31:0] rdat, s_sdat, s_adr;
    logic [3:0]  s_stb, s_cyc, s_sel, s_ack;
    logic [15:0] cnt;
    logic [31:0] slave_rd [NS];
    logic [127:0] s_dat_in;
    logic [3:0] resp_ack = '0, noise_ack = '0, inject_ack = '0;
    bit noise_en = 1'b0;
    int slave_delay = 0;
    int cnt_r [NS];
    int preset_seq = 0, preset_seen = 0;
    int n_err = 0, n_checks = 0;

    // Reference model state and expected outputs.
    bit m_busy, m_resp;
    int m_idx, m_wait;
    logic exp_ack, exp_err, exp_irq, exp_we;
    logic [3:0] exp_stb, exp_sel;
    logic [31:0] exp_rdat, exp_sdat, exp_adr;
    logic [15:0] exp_cnt;

    // Transaction results.
    int lat;
    logic g_ack, g_err, g_irq;
    logic [31:0] g_dat;
    logic [15:0] g_cnt;
    logic [3:0] g_first, g_seen;

    always #5 clk = ~clk;

    assign s_dat_in = {slave_rd[3], slave_rd[2], slave_rd[1], slave_rd[0]};
    assign s_ack    = resp_ack | noise_ack | inject_ack;

    wishbone_mux_n #(
        .NUM_SLAVES(NS),
        .BASE_ADDRS({32'h3000_C000, 32'h3000_8000, 32'h3000_4000, 32'h3000_0000}),
        .ADDR_WIDTHS({8'd11, 8'd11, 8'd11, 8'd11}),
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA(ERRD)
    ) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(mdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(rdat),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_dat_o(s_sdat), .s_adr_o(s_adr), .s_ack_i(s_ack), .s_dat_i(s_dat_in),
        .err_irq_o(irq), .err_count_o(cnt)
    );

    // Window lookup by address range; first matching slave in index order.
    function automatic int decode(input logic [31:0] a);
        longint unsigned span, lo, av;
        decode = -1;
        av = {32'd0, a};
        for (int i = NS - 1; i >= 0; i--) begin
            span = 64'd1 << WID[i];
            lo   = ({32'd0, BASE[i]} / span) * span;
            if (av >= lo && av < lo + span) decode = i;
        end
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Slaves ack after slave_delay strobe cycles; optional ack noise on unselected slaves.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (s_stb[i] && !resp_ack[i]) begin
                if (cnt_r[i] >= slave_delay) resp_ack[i] <= 1'b1;
                cnt_r[i] <= cnt_r[i] + 1;
            end else begin
                resp_ack[i] <= 1'b0;
                cnt_r[i]    <= 0;
            end
        end
        noise_ack <= noise_en ? (4'($urandom) & ~s_stb) : 4'b0;
    end

    // Reference model: one master transaction at a time, outputs for the next cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_idx <= 0; m_wait <= 0;
            preset_seen <= preset_seq;
            exp_ack <= 1'b0; exp_err <= 1'b0; exp_irq <= 1'b0; exp_stb <= '0;
            exp_rdat <= '0; exp_we <= 1'b0; exp_sel <= '0; exp_sdat <= '0;
            exp_adr <= '0; exp_cnt <= '0;
        end else begin
            exp_ack <= 1'b0; exp_err <= 1'b0; exp_irq <= 1'b0; exp_stb <= '0;
            preset_seen <= preset_seq;
            if (preset_seq != preset_seen) exp_cnt <= 16'hFFFE;
            if (m_resp) begin
                m_resp <= 1'b0;
            end else if (!m_busy) begin
                if (cyc && stb) begin
                    if (decode(adr) >= 0) begin
                        m_busy <= 1'b1; m_idx <= decode(adr); m_wait <= 0;
                        exp_stb <= 4'b1 << decode(adr);
                        exp_we <= we; exp_sel <= sel; exp_sdat <= mdat; exp_adr <= adr;
                    end else begin
                        m_resp <= 1'b1; exp_ack <= 1'b1; exp_err <= 1'b1; exp_irq <= 1'b1;
                        exp_rdat <= ERRD;
                        exp_cnt <= bump((preset_seq != preset_seen) ? 16'hFFFE : exp_cnt);
                    end
                end
            end else if (!cyc) begin
                m_busy <= 1'b0;
            end else if (s_ack[m_idx]) begin
                m_busy <= 1'b0; m_resp <= 1'b1; exp_ack <= 1'b1; exp_rdat <= slave_rd[m_idx];
            end else if (TO != 0 && m_wait + 1 == TO) begin
                m_busy <= 1'b0; m_resp <= 1'b1; exp_ack <= 1'b1; exp_err <= 1'b1;
                exp_irq <= 1'b1; exp_rdat <= ERRD;
                exp_cnt <= bump((preset_seq != preset_seen) ? 16'hFFFE : exp_cnt);
            end else begin
                m_wait <= m_wait + 1;
                exp_stb <= 4'b1 << m_idx;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_outputs();
        check("wbs_ack_o",   32'(ack),    32'(exp_ack));
        check("wbs_err_o",   32'(err),    32'(exp_err));
        check("wbs_dat_o",   rdat,        exp_rdat);
        check("err_irq_o",   32'(irq),    32'(exp_irq));
        check("err_count_o", 32'(cnt),    32'(exp_cnt));
        check("s_stb_o",     32'(s_stb),  32'(exp_stb));
        check("s_cyc_o",     32'(s_cyc),  32'(exp_stb));
        check("s_we_o",      32'(s_we),   32'(exp_we));
        check("s_sel_o",     32'(s_sel),  32'(exp_sel));
        check("s_dat_o",     s_sdat,      exp_sdat);
        check("s_adr_o",     s_adr,       exp_adr);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic go(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] sl, input int delay, input int abort_at);
        bit done;
        done = 1'b0;
        slave_delay = delay;
        adr = a; we = w; mdat = d; sel = sl; cyc = 1'b1; stb = 1'b1;
        lat = 0; g_ack = 1'b0; g_err = 1'b0; g_irq = 1'b0; g_dat = '0; g_cnt = '0;
        g_first = '0; g_seen = '0;
        for (int n = 1; n <= TO + 20 && !done; n++) begin
            tick();
            g_seen = g_seen | s_stb;
            if (g_first == 4'b0) g_first = s_stb;
            if (ack) begin
                g_ack = 1'b1; g_err = err; g_dat = rdat; g_irq = irq; g_cnt = cnt;
                lat = n; done = 1'b1;
            end else if (n == abort_at) begin
                done = 1'b1;
            end
        end
        if (!done) check("ack_wait_bound", 32'd0, 32'd1);
        cyc = 1'b0; stb = 1'b0;
    endtask

    initial begin
        int k, dly, ab, acks;
        logic [31:0] a;
        for (int i = 0; i < NS; i++) slave_rd[i] = $urandom;

        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_stb", 32'(s_stb), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_adr", s_adr, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        slave_rd[0] = 32'h1234_5678;
        go(32'h3000_0010, 1'b0, 32'h0, 4'hF, 2, 0);
        check("rd_first_stb", 32'(g_first), 32'h1);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_err", 32'(g_err), 32'd0);
        check("rd_data", g_dat, 32'h1234_5678);
        tick();
        check("rd_ack_one_cycle", 32'(ack), 32'd0);

        go(32'h3000_4004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 0);
        check("wr_stb", 32'(g_seen), 32'b0010);
        check("wr_ack", 32'(g_ack), 32'd1);
        check("wr_err", 32'(g_err), 32'd0);
        check("wr_sdat", s_sdat, 32'hA5A5_A5A5);
        check("wr_sel", 32'(s_sel), 32'b0011);
        check("wr_we", 32'(s_we), 32'd1);
        tick();

        go(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 0);
        check("miss_latency", 32'(lat), 32'd1);
        check("miss_err", 32'(g_err), 32'd1);
        check("miss_data", g_dat, 32'hDEAD_BEEF);
        check("miss_irq", 32'(g_irq), 32'd1);
        check("miss_count", 32'(g_cnt), 32'd1);
        check("miss_no_stb", 32'(g_seen), 32'd0);
        tick();
        check("miss_irq_pulse", 32'(irq), 32'd0);

        go(32'h3000_8000, 1'b0, 32'h0, 4'hF, NEVER, 0);
        check("to_latency", 32'(lat), 32'd256);
        check("to_err", 32'(g_err), 32'd1);
        check("to_count", 32'(g_cnt), 32'd2);
        tick(); tick();
        inject_ack = 4'b0100;
        tick();
        inject_ack = 4'b0000;
        acks = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (ack) acks++; end
        check("late_ack_ignored", 32'(acks), 32'd0);

        go(32'h3000_4100, 1'b0, 32'h0, 4'hF, NEVER, 5);
        check("abort_no_ack", 32'(g_ack), 32'd0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (ack) acks++; end
        check("abort_acks", 32'(acks), 32'd0);
        check("abort_count", 32'(cnt), 32'd2);
        check("abort_stb", 32'(s_stb), 32'd0);

        slave_delay = NEVER;
        adr = 32'h3000_C100; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        tick(); tick(); tick();
        check("busy_stb", 32'(s_stb), 32'b1000);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_stb", 32'(s_stb), 32'd0);
        check("async_rst_cyc", 32'(s_cyc), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        check("async_rst_cnt", 32'(cnt), 32'd0);
        check("async_rst_adr", s_adr, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rstn = 1'b1;
        tick(); tick();
        check("post_rst_idle", 32'(s_stb), 32'd0);

        #1 force dut.err_count_o = 16'hFFFE;
        #1 release dut.err_count_o;
        preset_seq++;
        tick();
        for (int i = 0; i < 3; i++) begin
            go(32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 0);
            check("sat_irq", 32'(g_irq), 32'd1);
            check("sat_count", 32'(g_cnt), 32'hFFFF);
            tick();
        end

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        noise_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k == 6) begin
                a = $urandom;
            end else if (k == 7) begin
                case ($urandom_range(0, 5))
                    0: a = 32'h3000_07FC;
                    1: a = 32'h3000_0800;
                    2: a = 32'h3000_C7FF;
                    3: a = 32'h3000_C800;
                    4: a = 32'h2FFF_FFFF;
                    default: a = 32'h3000_3FFF;
                endcase
            end else begin
                a = BASE[$urandom_range(0, NS - 1)] + ($urandom & 32'h7FC);
            end
            dly = ($urandom_range(0, 99) < 3) ? NEVER : $urandom_range(0, 5);
            ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            for (int i = 0; i < NS; i++) slave_rd[i] = $urandom;
            go(a, 1'($urandom), $urandom, 4'($urandom), dly, ab);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
